// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI4 burst slave memory.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FILL, R_DATA} r_state_e;

  // WRAP, the reserved encoding and any non-32-bit beat size are answered with SLVERR.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size != SIZE_WORD);
  endfunction

endpackage

// File: rtl/axi_burst_slave_mem_ram.sv
// Simple dual-port word RAM: byte-enabled write port, registered read port, no reset.
module axi_burst_slave_mem_ram #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic [3:0]           we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  // Same-cycle read of a word being written returns the old contents.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_burst_slave_mem.sv
// AXI4 slave backed by on-chip RAM; independent INCR/FIXED read and write burst engines.
module axi_burst_slave_mem
  import axi_burst_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2     = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int WA = MEM_DEPTH_LOG2;

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;
  logic out_en;

  logic [C_S_AXI_ID_WIDTH-1:0] w_id, r_id;
  logic [WA-1:0] w_addr, r_addr, ram_raddr;
  logic [7:0]    w_len, r_len;
  logic          w_incr, r_incr, w_err, r_err, w_bad;
  logic [8:0]    w_cnt, r_iss;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_pop, w_last_beat;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata, push_data;
  logic          r_issue, r_issue_last, pipe_v, pipe_last;
  logic [2:0]    r_occ;
  logic [1:0]    fifo_cnt;
  logic [31:0]   e0_data, e1_data;
  logic          e0_last, e1_last;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:WA+2], S_AXI_AWADDR[1:0],
                              S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:WA+2], S_AXI_ARADDR[1:0]};

  assign aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs        = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs        = S_AXI_BVALID && S_AXI_BREADY;
  assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_pop       = S_AXI_RVALID && S_AXI_RREADY;
  assign w_last_beat = (w_cnt == {1'b0, w_len});

  // Holds the address channels off until the first clock after reset release.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) out_en <= 1'b0;
    else        out_en <= 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FILL;
      R_FILL:  r_next = R_DATA;
      R_DATA:  if (r_pop && S_AXI_RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = (w_state == W_IDLE) && out_en;
    S_AXI_WREADY  = (w_state == W_DATA);
    S_AXI_BVALID  = (w_state == W_RESP);
    S_AXI_ARREADY = (r_state == R_IDLE) && out_en;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_id   <= '0;
      w_addr <= '0;
      w_len  <= '0;
      w_incr <= 1'b0;
      w_err  <= 1'b0;
      w_bad  <= 1'b0;
      w_cnt  <= '0;
    end else begin
      if (aw_hs) begin
        w_id   <= S_AXI_AWID;
        w_addr <= S_AXI_AWADDR[WA+1:2];
        w_len  <= S_AXI_AWLEN;
        w_incr <= (S_AXI_AWBURST == BURST_INCR);
        w_err  <= burst_err(S_AXI_AWBURST, S_AXI_AWSIZE);
        w_bad  <= 1'b0;
        w_cnt  <= '0;
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 9'd1;
        if (w_incr) w_addr <= w_addr + WA'(1);
        if (S_AXI_WLAST != w_last_beat) w_bad <= 1'b1;
      end
    end
  end

  assign S_AXI_BID   = w_id;
  assign S_AXI_BRESP = (w_err || w_bad) ? RESP_SLVERR : RESP_OKAY;
  assign ram_we      = (w_hs && !w_err) ? S_AXI_WSTRB : 4'b0000;

  // First beat is fetched in the AR handshake cycle itself; later fetches are
  // credit-limited so the pipe stage plus the 2-entry buffer never overflows.
  assign r_occ = {1'b0, fifo_cnt} + {2'b00, pipe_v} - {2'b00, r_pop};

  always_comb begin
    r_issue      = 1'b0;
    ram_raddr    = r_addr;
    r_issue_last = (r_iss == {1'b0, r_len});
    if (ar_hs) begin
      r_issue      = 1'b1;
      ram_raddr    = S_AXI_ARADDR[WA+1:2];
      r_issue_last = (S_AXI_ARLEN == 8'd0);
    end else if (r_state != R_IDLE && r_iss <= {1'b0, r_len} && r_occ <= 3'd1) begin
      r_issue = 1'b1;
    end
  end

  assign push_data = r_err ? '0 : ram_rdata;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_incr    <= 1'b0;
      r_err     <= 1'b0;
      r_iss     <= '0;
      pipe_v    <= 1'b0;
      pipe_last <= 1'b0;
      fifo_cnt  <= '0;
      e0_data   <= '0;
      e1_data   <= '0;
      e0_last   <= 1'b0;
      e1_last   <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id   <= S_AXI_ARID;
        r_len  <= S_AXI_ARLEN;
        r_incr <= (S_AXI_ARBURST == BURST_INCR);
        r_err  <= burst_err(S_AXI_ARBURST, S_AXI_ARSIZE);
        r_addr <= S_AXI_ARADDR[WA+1:2] + WA'(S_AXI_ARBURST == BURST_INCR);
        r_iss  <= 9'd1;
      end else if (r_issue) begin
        r_iss <= r_iss + 9'd1;
        if (r_incr) r_addr <= r_addr + WA'(1);
      end
      pipe_v    <= r_issue;
      pipe_last <= r_issue_last;
      case ({pipe_v, r_pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            e0_data <= push_data;
            e0_last <= pipe_last;
          end else begin
            e1_data <= push_data;
            e1_last <= pipe_last;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          e0_data  <= e1_data;
          e0_last  <= e1_last;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            e0_data <= push_data;
            e0_last <= pipe_last;
          end else begin
            e0_data <= e1_data;
            e0_last <= e1_last;
            e1_data <= push_data;
            e1_last <= pipe_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign S_AXI_RVALID = (fifo_cnt != 2'd0);
  assign S_AXI_RDATA  = e0_data;
  assign S_AXI_RLAST  = e0_last;
  assign S_AXI_RID    = r_id;
  assign S_AXI_RRESP  = r_err ? RESP_SLVERR : RESP_OKAY;

  axi_burst_slave_mem_ram #(.ADDR_BITS(WA)) u_ram (
    .clk   (ACLK),
    .we    (ram_we),
    .waddr (w_addr),
    .wdata (S_AXI_WDATA),
    .re    (r_issue),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Scoreboard bench for axi_burst_slave_mem: directed bursts, expected beats queued at issue.
`timescale 1ns/1ps
module tb_axi_burst_slave_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        awid, wlast, wvalid, awvalid, arvalid, arid;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic [3:0]  wstrb;
  logic        bready = 1'b1;
  logic        rready = 1'b0;
  logic        awready, wready, bid, bvalid, arready, rid, rlast, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  axi_burst_slave_mem #(
    .C_S_AXI_ID_WIDTH(1), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .MEM_DEPTH_LOG2(10)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct {logic [31:0] data; logic [1:0] resp; logic last; logic id;} r_exp_t;
  typedef struct {logic id; logic [1:0] resp;} b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];
  r_exp_t r_e;
  b_exp_t b_e;
  int n_cmp = 0;
  int n_err = 0;
  int r_seen = 0;
  int base_seen;
  int unsigned tcnt;
  bit rr_toggle = 1'b0;
  logic [31:0] prev_data;
  logic prev_last;
  logic prev_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s_timeout: got no handshake expected one (t=%0t)", name, $time);
  endtask

  always begin
    @(posedge clk);
    #1;
    rready = rr_toggle ? ~rready : 1'b1;
  end

  // Monitor: pops the scoreboard on every R/B handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("r_hold_valid", 32'(rvalid), 32'd1);
        check("r_hold_data", rdata, prev_data);
        check("r_hold_last", 32'(rlast), 32'(prev_last));
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL r_unexpected: got beat %h expected none", rdata);
        end else begin
          r_e = rq.pop_front();
          check("r_data", rdata, r_e.data);
          check("r_resp", 32'(rresp), 32'(r_e.resp));
          check("r_last", 32'(rlast), 32'(r_e.last));
          check("r_id", 32'(rid), 32'(r_e.id));
        end
        r_seen++;
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL b_unexpected: got resp %0d expected none", bresp);
        end else begin
          b_e = bq.pop_front();
          check("b_resp", 32'(bresp), 32'(b_e.resp));
          check("b_id", 32'(bid), 32'(b_e.id));
        end
      end
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
      prev_last  = rlast;
    end
  end

  task automatic do_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [2:0] size);
    int unsigned t = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!awready && t < 100);
    if (!awready) timeout("aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    int unsigned t = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!wready && t < 100);
    if (!wready) timeout("w");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [2:0] size);
    int unsigned t = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    do begin @(negedge clk); t++; end while (!arready && t < 100);
    if (!arready) timeout("ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d R and %0d B pending expected 0", rq.size(), bq.size());
      rq.delete();
      bq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wr_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [31:0] base,
                          input logic [3:0] strb, input int last_idx, input logic [1:0] eresp);
    bq.push_back('{id: id, resp: eresp});
    do_aw(id, addr, len, burst, size);
    for (int i = 0; i <= int'(len); i++) do_w(base + 32'(i), strb, i == last_idx);
    drain();
  endtask

  task automatic push_r(input logic id, input logic [7:0] len, input logic [31:0] ebase,
                        input logic [31:0] estep, input logic [1:0] eresp);
    for (int i = 0; i <= int'(len); i++)
      rq.push_back('{data: ebase + estep * 32'(i), resp: eresp, last: (i == int'(len)), id: id});
  endtask

  task automatic rd_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [31:0] ebase,
                          input logic [31:0] estep, input logic [1:0] eresp);
    push_r(id, len, ebase, estep, eresp);
    do_ar(id, addr, len, burst, size);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    awid = 0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0;
    arid = 0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_bresp", 32'(bresp), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", rdata, 0);
    check("rst_rlast", 32'(rlast), 0);
    check("rst_rresp", 32'(rresp), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #6;
    check("rel_awready_pre", 32'(awready), 0);
    check("rel_arready_pre", 32'(arready), 0);
    @(posedge clk); #1;
    check("rel_awready", 32'(awready), 1);
    check("rel_arready", 32'(arready), 1);

    wr_burst(1'b1, 32'h40, 8'd15, 2'b01, 3'b010, 32'd0, 4'hF, 15, 2'b00);
    rd_burst(1'b0, 32'h40, 8'd15, 2'b01, 3'b010, 32'd0, 32'd1, 2'b00);

    rr_toggle = 1'b1;
    rd_burst(1'b1, 32'h40, 8'd3, 2'b01, 3'b010, 32'd0, 32'd1, 2'b00);
    rr_toggle = 1'b0;

    wr_burst(1'b0, 32'h8, 8'd0, 2'b01, 3'b010, 32'h11223344, 4'hF, 0, 2'b00);
    wr_burst(1'b0, 32'h8, 8'd0, 2'b01, 3'b010, 32'hAABBCCDD, 4'b0011, 0, 2'b00);
    rd_burst(1'b0, 32'h8, 8'd0, 2'b01, 3'b010, 32'h1122CCDD, 32'd0, 2'b00);

    wr_burst(1'b1, 32'h100, 8'd3, 2'b00, 3'b010, 32'd1, 4'hF, 3, 2'b00);
    rd_burst(1'b1, 32'h100, 8'd0, 2'b01, 3'b010, 32'd4, 32'd0, 2'b00);
    rd_burst(1'b0, 32'h100, 8'd2, 2'b00, 3'b010, 32'd4, 32'd0, 2'b00);
    wr_burst(1'b0, 32'h100, 8'd1, 2'b10, 3'b010, 32'hDEADBEEF, 4'hF, 1, 2'b10);
    rd_burst(1'b0, 32'h100, 8'd0, 2'b01, 3'b010, 32'd4, 32'd0, 2'b00);

    rd_burst(1'b1, 32'h40, 8'd3, 2'b10, 3'b010, 32'd0, 32'd0, 2'b10);
    rd_burst(1'b0, 32'h40, 8'd0, 2'b01, 3'b011, 32'd0, 32'd0, 2'b10);
    wr_burst(1'b1, 32'h200, 8'd3, 2'b01, 3'b010, 32'h50, 4'hF, 1, 2'b10);

    // 0x1040 aliases onto 0x40 in a 4 KB memory.
    rd_burst(1'b0, 32'h1040, 8'd1, 2'b01, 3'b010, 32'd0, 32'd1, 2'b00);

    wr_burst(1'b1, 32'h400, 8'd255, 2'b01, 3'b010, 32'h1000, 4'hF, 255, 2'b00);
    rd_burst(1'b1, 32'h400, 8'd255, 2'b01, 3'b010, 32'h1000, 32'd1, 2'b00);

    base_seen = r_seen;
    tcnt = 0;
    push_r(1'b0, 8'd7, 32'd0, 32'd1, 2'b00);
    do_ar(1'b0, 32'h40, 8'd7, 2'b01, 3'b010);
    while (r_seen < base_seen + 2 && tcnt < 100) begin
      @(posedge clk); #2;
      tcnt++;
    end
    check("mid_beat3_valid", 32'(rvalid), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_arready", 32'(arready), 0);
    rq.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #5;
    check("mid_rel_arready_pre", 32'(arready), 0);
    @(posedge clk); #1;
    check("mid_rel_arready", 32'(arready), 1);
    rd_burst(1'b1, 32'h40, 8'd3, 2'b01, 3'b010, 32'd0, 32'd1, 2'b00);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
